// File: rtl/exe_mem_stage_pkg.sv
// Shared opcode/sub-field constants, ALU operation encoding and instruction decode
// helpers for the EXE stage of the 16-bit CPU.
package exe_mem_stage_pkg;

  localparam int          DATA_W_DEF     = 16;
  localparam int          REG_ADDR_W_DEF = 4;
  localparam logic [15:0] NOP_OPN_DEF    = 16'h0800;

  // Major opcode, opn[15:11]
  localparam logic [4:0] OP_SHIFT  = 5'b00110;
  localparam logic [4:0] OP_ADDIU3 = 5'b01000;
  localparam logic [4:0] OP_ADDIU  = 5'b01001;
  localparam logic [4:0] OP_SP_GRP = 5'b01100;
  localparam logic [4:0] OP_LI     = 5'b01101;
  localparam logic [4:0] OP_MOVE   = 5'b01111;
  localparam logic [4:0] OP_LW_SP  = 5'b10010;
  localparam logic [4:0] OP_LW     = 5'b10011;
  localparam logic [4:0] OP_SW_SP  = 5'b11010;
  localparam logic [4:0] OP_SW     = 5'b11011;
  localparam logic [4:0] OP_RRR    = 5'b11100;
  localparam logic [4:0] OP_RR     = 5'b11101;
  localparam logic [4:0] OP_IH     = 5'b11110;

  // Sub-fields
  localparam logic [2:0] F_ADDSP = 3'b011;  // opn[10:8] in the SP group
  localparam logic [2:0] F_MTSP  = 3'b100;
  localparam logic [1:0] F_ADDU  = 2'b01;   // opn[1:0] in RRR / SHIFT
  localparam logic [1:0] F_SUBU  = 2'b11;
  localparam logic [1:0] F_SLL   = 2'b00;
  localparam logic [1:0] F_SRL   = 2'b10;
  localparam logic [1:0] F_SRA   = 2'b11;
  localparam logic [4:0] F_SRAV  = 5'b00111; // opn[4:0] in RR / IH
  localparam logic [4:0] F_CMP   = 5'b01010;
  localparam logic [4:0] F_AND   = 5'b01100;
  localparam logic [4:0] F_OR    = 5'b01101;
  localparam logic [4:0] F_PC_JR = 5'b00000;
  localparam logic [2:0] RY_MFPC = 3'b010;   // opn[7:5] separates MFPC from JR
  localparam logic [4:0] F_MFIH  = 5'b00000;
  localparam logic [4:0] F_MTIH  = 5'b00001;

  typedef enum logic [3:0] {
    ALU_ZERO,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_PASS1,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SRAV
  } alu_op_e;

  function automatic alu_op_e decode_alu(input logic [15:0] opn);
    alu_op_e op;
    op = ALU_ZERO;
    case (opn[15:11])
      OP_ADDIU, OP_ADDIU3, OP_LW, OP_LW_SP,
      OP_SW, OP_SW_SP, OP_LI, OP_MOVE: op = ALU_ADD;
      OP_SP_GRP: begin
        if (opn[10:8] == F_ADDSP)     op = ALU_ADD;
        else if (opn[10:8] == F_MTSP) op = ALU_PASS1;
      end
      OP_RRR: begin
        if (opn[1:0] == F_ADDU)      op = ALU_ADD;
        else if (opn[1:0] == F_SUBU) op = ALU_SUB;
      end
      OP_RR: begin
        case (opn[4:0])
          F_AND:   op = ALU_AND;
          F_OR:    op = ALU_OR;
          F_SRAV:  op = ALU_SRAV;
          F_PC_JR: if (opn[7:5] == RY_MFPC) op = ALU_PASS1;
          default: op = ALU_ZERO;
        endcase
      end
      OP_IH: if (opn[4:0] == F_MFIH || opn[4:0] == F_MTIH) op = ALU_PASS1;
      OP_SHIFT: begin
        case (opn[1:0])
          F_SLL:   op = ALU_SLL;
          F_SRL:   op = ALU_SRL;
          F_SRA:   op = ALU_SRA;
          default: op = ALU_ZERO;
        endcase
      end
      default: op = ALU_ZERO;
    endcase
    return op;
  endfunction

  function automatic logic is_cmp(input logic [15:0] opn);
    return (opn[15:11] == OP_RR) && (opn[4:0] == F_CMP);
  endfunction

endpackage

// File: rtl/exe_mem_stage_if.sv
// id_exe -> EXE/MEM bundle: instruction fields from id_exe, ID hazard query, and the
// registered EXE/MEM outputs toward MEM plus the hazard answer back to ID.
interface exe_mem_stage_if #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 4
);
  // No valid/ready pair: a new instruction is taken every edge unless hold=1 (all state
  // frozen) or flush=1 (a bubble is latched instead); flush beats hold.
  logic                  hold;
  logic                  flush;
  logic [15:0]           opn;
  logic [15:0]           pc;
  logic [DATA_W-1:0]     op1;
  logic [DATA_W-1:0]     op2;
  logic [DATA_W-1:0]     read_value1;
  logic [DATA_W-1:0]     read_value2;
  logic                  mem_write;
  logic                  mem_read;
  logic                  reg_write;
  logic [REG_ADDR_W-1:0] reg_addr;
  logic [REG_ADDR_W-1:0] id_rx_addr;
  logic [REG_ADDR_W-1:0] id_ry_addr;
  logic                  id_uses_rx;
  logic                  id_uses_ry;

  logic [DATA_W-1:0]     alu_result;
  logic [DATA_W-1:0]     store_value;
  logic                  mem_write_out;
  logic                  mem_read_out;
  logic                  reg_write_out;
  logic [REG_ADDR_W-1:0] reg_addr_out;
  logic [15:0]           pc_out;
  logic [15:0]           opn_out;
  logic                  t_out;
  logic                  load_use_stall;

  modport slave (
    input  hold, flush, opn, pc, op1, op2, read_value1, read_value2,
           mem_write, mem_read, reg_write, reg_addr,
           id_rx_addr, id_ry_addr, id_uses_rx, id_uses_ry,
    output alu_result, store_value, mem_write_out, mem_read_out, reg_write_out,
           reg_addr_out, pc_out, opn_out, t_out, load_use_stall
  );

  modport master (
    output hold, flush, opn, pc, op1, op2, read_value1, read_value2,
           mem_write, mem_read, reg_write, reg_addr,
           id_rx_addr, id_ry_addr, id_uses_rx, id_uses_ry,
    input  alu_result, store_value, mem_write_out, mem_read_out, reg_write_out,
           reg_addr_out, pc_out, opn_out, t_out, load_use_stall
  );
endinterface

// File: rtl/exe_mem_stage_alu.sv
// Combinational EXE ALU: decodes opn and produces the 16-bit wrap-around result and
// the operand inequality used by CMP.
module exe_alu
  import exe_mem_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [15:0]       opn,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  output logic [DATA_W-1:0] result,
  output logic              cmp_ne
);

  logic [3:0] sh;

  // A zero immediate shift amount encodes a shift by 8.
  assign sh     = (op2[2:0] == 3'd0) ? 4'd8 : {1'b0, op2[2:0]};
  assign cmp_ne = (op1 != op2);

  always_comb begin
    result = '0;
    case (decode_alu(opn))
      ALU_ADD:   result = op1 + op2;
      ALU_SUB:   result = op1 - op2;
      ALU_AND:   result = op1 & op2;
      ALU_OR:    result = op1 | op2;
      ALU_PASS1: result = op1;
      ALU_SLL:   result = op1 << sh;
      ALU_SRL:   result = op1 >> sh;
      ALU_SRA:   result = $signed(op1) >>> sh;
      ALU_SRAV:  result = $signed(op2) >>> op1[3:0];
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/exe_mem_stage.sv
// EXE stage with EXE/MEM pipeline register: ALU, T flag, store-data select and the
// load-use hazard request back to ID.
module exe_mem_stage
  import exe_mem_stage_pkg::*;
#(
  parameter int          DATA_W     = DATA_W_DEF,
  parameter int          REG_ADDR_W = REG_ADDR_W_DEF,
  parameter logic [15:0] NOP_OPN    = NOP_OPN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  exe_mem_stage_if.slave   bus
);

  logic [DATA_W-1:0]     alu_res;
  logic                  cmp_ne;
  logic [DATA_W-1:0]     store_sel;

  logic [DATA_W-1:0]     alu_result_q, alu_result_d;
  logic [DATA_W-1:0]     store_value_q, store_value_d;
  logic                  mem_write_q, mem_write_d;
  logic                  mem_read_q, mem_read_d;
  logic                  reg_write_q, reg_write_d;
  logic [REG_ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [15:0]           pc_q, pc_d;
  logic [15:0]           opn_q, opn_d;
  logic                  t_q, t_d;

  exe_alu #(.DATA_W(DATA_W)) u_alu (
    .opn    (bus.opn),
    .op1    (bus.op1),
    .op2    (bus.op2),
    .result (alu_res),
    .cmp_ne (cmp_ne)
  );

  always_comb begin
    store_sel = '0;
    case (bus.opn[15:11])
      OP_SW:    store_sel = bus.read_value2;
      OP_SW_SP: store_sel = bus.read_value1;
      default:  store_sel = '0;
    endcase
  end

  always_comb begin
    alu_result_d  = alu_result_q;
    store_value_d = store_value_q;
    mem_write_d   = mem_write_q;
    mem_read_d    = mem_read_q;
    reg_write_d   = reg_write_q;
    reg_addr_d    = reg_addr_q;
    pc_d          = pc_q;
    opn_d         = opn_q;
    t_d           = t_q;
    if (bus.flush) begin
      // Bubble: nothing may write memory or the register file; T is untouched.
      alu_result_d  = '0;
      store_value_d = '0;
      mem_write_d   = 1'b0;
      mem_read_d    = 1'b0;
      reg_write_d   = 1'b0;
      reg_addr_d    = '0;
      pc_d          = '0;
      opn_d         = NOP_OPN;
    end else if (!bus.hold) begin
      alu_result_d  = alu_res;
      store_value_d = store_sel;
      mem_write_d   = bus.mem_write;
      mem_read_d    = bus.mem_read;
      reg_write_d   = bus.reg_write;
      reg_addr_d    = bus.reg_addr;
      pc_d          = bus.pc;
      opn_d         = bus.opn;
      if (is_cmp(bus.opn)) t_d = cmp_ne;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_result_q  <= '0;
      store_value_q <= '0;
      mem_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      reg_write_q   <= 1'b0;
      reg_addr_q    <= '0;
      pc_q          <= '0;
      opn_q         <= NOP_OPN;
      t_q           <= 1'b0;
    end else begin
      alu_result_q  <= alu_result_d;
      store_value_q <= store_value_d;
      mem_write_q   <= mem_write_d;
      mem_read_q    <= mem_read_d;
      reg_write_q   <= reg_write_d;
      reg_addr_q    <= reg_addr_d;
      pc_q          <= pc_d;
      opn_q         <= opn_d;
      t_q           <= t_d;
    end
  end

  assign bus.alu_result    = alu_result_q;
  assign bus.store_value   = store_value_q;
  assign bus.mem_write_out = mem_write_q;
  assign bus.mem_read_out  = mem_read_q;
  assign bus.reg_write_out = reg_write_q;
  assign bus.reg_addr_out  = reg_addr_q;
  assign bus.pc_out        = pc_q;
  assign bus.opn_out       = opn_q;
  assign bus.t_out         = t_q;

  // Driven from the latched load so the request clears the cycle after a flush.
  assign bus.load_use_stall = rst & mem_read_q & reg_write_q &
                              ((bus.id_uses_rx & (bus.id_rx_addr == reg_addr_q)) |
                               (bus.id_uses_ry & (bus.id_ry_addr == reg_addr_q)));

endmodule

// File: tb/tb_exe_mem_stage.sv
// Bench for exe_mem_stage: table of ALU/store vectors plus hand-written sequences for
// T flag, hold/flush priority, load-use hazard and asynchronous reset.
module tb_exe_mem_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  exe_mem_stage_if #(.DATA_W(16), .REG_ADDR_W(4)) bus ();

  exe_mem_stage #(.DATA_W(16), .REG_ADDR_W(4), .NOP_OPN(16'h0800)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] opn, op1, op2, rv1, rv2;
    logic        mw, mr, rw;
    logic [3:0]  raddr;
    logic [15:0] exp_res, exp_st;
  } vec_t;

  // {full, result, store, mw, mr, rw, raddr, pc, opn}; full=0 skips store/raddr/pc
  logic [71:0] exp_q[$];
  logic [71:0] last_exp;
  logic        t_exp;
  int          n_checks = 0;
  int          n_fail   = 0;
  vec_t        tbl[18];

  function automatic vec_t mk(logic [15:0] opn, op1, op2, rv1, rv2,
                              logic mw, mr, rw, logic [3:0] ra,
                              logic [15:0] res, st);
    vec_t v;
    v.opn = opn; v.op1 = op1; v.op2 = op2; v.rv1 = rv1; v.rv2 = rv2;
    v.mw = mw; v.mr = mr; v.rw = rw; v.raddr = ra; v.exp_res = res; v.exp_st = st;
    return v;
  endfunction

  function automatic logic [71:0] pack(logic full, logic [15:0] res, st,
                                       logic mw, mr, rw, logic [3:0] ra,
                                       logic [15:0] pc, opn);
    return {full, res, st, mw, mr, rw, ra, pc, opn};
  endfunction

  task automatic chk(input string name, input int tag, input logic [15:0] act, exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, tag, act, exp);
    end
  endtask

  task automatic check_out(input int tag);
    logic [71:0] e;
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard step %0d: expected queue empty", tag);
      return;
    end
    e = exp_q.pop_front();
    chk("alu_result", tag, bus.alu_result, e[70:55]);
    chk("mem_write_out", tag, {15'd0, bus.mem_write_out}, {15'd0, e[38]});
    chk("mem_read_out", tag, {15'd0, bus.mem_read_out}, {15'd0, e[37]});
    chk("reg_write_out", tag, {15'd0, bus.reg_write_out}, {15'd0, e[36]});
    chk("opn_out", tag, bus.opn_out, e[15:0]);
    chk("t_out", tag, {15'd0, bus.t_out}, {15'd0, t_exp});
    if (e[71]) begin
      chk("store_value", tag, bus.store_value, e[54:39]);
      chk("reg_addr_out", tag, {12'd0, bus.reg_addr_out}, {12'd0, e[35:32]});
      chk("pc_out", tag, bus.pc_out, e[31:16]);
    end
  endtask

  task automatic check_stall(input logic exp, input int tag);
    #1;
    chk("load_use_stall", tag, {15'd0, bus.load_use_stall}, {15'd0, exp});
  endtask

  task automatic step(input vec_t v, input logic h, input logic f, input int tag);
    logic [71:0] e;
    logic [15:0] pcv;
    @(negedge clk);
    pcv = 16'($urandom_range(0, 65535));
    bus.opn = v.opn; bus.op1 = v.op1; bus.op2 = v.op2;
    bus.read_value1 = v.rv1; bus.read_value2 = v.rv2;
    bus.mem_write = v.mw; bus.mem_read = v.mr; bus.reg_write = v.rw;
    bus.reg_addr = v.raddr; bus.pc = pcv;
    bus.hold = h; bus.flush = f;
    if (f)      e = pack(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0, 16'h0800);
    else if (h) e = last_exp;
    else        e = pack(1'b1, v.exp_res, v.exp_st, v.mw, v.mr, v.rw, v.raddr, pcv, v.opn);
    if (!f && !h && v.opn == 16'hE80A) t_exp = (v.op1 != v.op2);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_out(tag);
    last_exp = e;
    bus.hold = 1'b0;
    bus.flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t cmp55, cmp56, sw, lw3, addiu, nop;
    tbl[0]  = mk(16'h4901, 16'h7FFF, 16'h0001, 16'h0, 16'h0, 0, 0, 1, 4'd1, 16'h8000, 16'h0);
    tbl[1]  = mk(16'hE003, 16'h0000, 16'h0001, 16'h0, 16'h0, 0, 0, 1, 4'd2, 16'hFFFF, 16'h0);
    tbl[2]  = mk(16'h3000, 16'h0001, 16'h0000, 16'h0, 16'h0, 0, 0, 1, 4'd3, 16'h0100, 16'h0);
    tbl[3]  = mk(16'h3003, 16'h8000, 16'h0001, 16'h0, 16'h0, 0, 0, 1, 4'd4, 16'hC000, 16'h0);
    tbl[4]  = mk(16'hE807, 16'h0004, 16'hF000, 16'h0, 16'h0, 0, 0, 1, 4'd5, 16'hFF00, 16'h0);
    tbl[5]  = mk(16'h3002, 16'hFF00, 16'h0000, 16'h0, 16'h0, 0, 0, 1, 4'd6, 16'h00FF, 16'h0);
    tbl[6]  = mk(16'hE80C, 16'hF0F0, 16'h3C3C, 16'h0, 16'h0, 0, 0, 1, 4'd7, 16'h3030, 16'h0);
    tbl[7]  = mk(16'hE80D, 16'hF0F0, 16'h0F0F, 16'h0, 16'h0, 0, 0, 1, 4'd8, 16'hFFFF, 16'h0);
    tbl[8]  = mk(16'hE840, 16'h1234, 16'h5555, 16'h0, 16'h0, 0, 0, 1, 4'd9, 16'h1234, 16'h0);
    tbl[9]  = mk(16'hD800, 16'h0010, 16'h0004, 16'h1111, 16'hBEEF, 1, 0, 0, 4'd0, 16'h0014, 16'hBEEF);
    tbl[10] = mk(16'hD000, 16'h0020, 16'h0003, 16'hCAFE, 16'h2222, 1, 0, 0, 4'd0, 16'h0023, 16'hCAFE);
    tbl[11] = mk(16'h9800, 16'h0100, 16'h0002, 16'h3333, 16'h4444, 0, 1, 1, 4'd3, 16'h0102, 16'h0);
    tbl[12] = mk(16'hE80A, 16'h0005, 16'h0006, 16'h0, 16'h0, 0, 0, 0, 4'd0, 16'h0000, 16'h0);
    tbl[13] = mk(16'h6000, 16'h0007, 16'h0008, 16'h0, 16'h0, 0, 0, 0, 4'd0, 16'h0000, 16'h0);
    tbl[14] = mk(16'h6800, 16'h00AB, 16'h0000, 16'h0, 16'h0, 0, 0, 1, 4'd10, 16'h00AB, 16'h0);
    tbl[15] = mk(16'h0800, 16'h1111, 16'h2222, 16'h0, 16'h0, 0, 0, 0, 4'd0, 16'h0000, 16'h0);
    tbl[16] = mk(16'h6300, 16'hFFFF, 16'h0002, 16'h0, 16'h0, 0, 0, 1, 4'd11, 16'h0001, 16'h0);
    tbl[17] = mk(16'hF001, 16'h4321, 16'h0009, 16'h0, 16'h0, 0, 0, 0, 4'd0, 16'h4321, 16'h0);

    cmp55 = mk(16'hE80A, 16'h0005, 16'h0005, 16'h0, 16'h0, 0, 0, 0, 4'd0, 16'h0, 16'h0);
    cmp56 = mk(16'hE80A, 16'h0005, 16'h0006, 16'h0, 16'h0, 0, 0, 0, 4'd0, 16'h0, 16'h0);
    sw    = mk(16'hD800, 16'h0040, 16'h0001, 16'h5A5A, 16'hBEEF, 1, 0, 0, 4'd2, 16'h0041, 16'hBEEF);
    lw3   = mk(16'h9800, 16'h0200, 16'h0004, 16'h0, 16'h0, 0, 1, 1, 4'd3, 16'h0204, 16'h0);
    addiu = mk(16'h4901, 16'h7FFF, 16'h0001, 16'h0, 16'h0, 0, 0, 1, 4'd1, 16'h8000, 16'h0);
    nop   = mk(16'h0800, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 4'd0, 16'h0, 16'h0);

    bus.hold = 0; bus.flush = 0; bus.opn = 16'h0800; bus.pc = 0;
    bus.op1 = 0; bus.op2 = 0; bus.read_value1 = 0; bus.read_value2 = 0;
    bus.mem_write = 0; bus.mem_read = 0; bus.reg_write = 0; bus.reg_addr = 0;
    bus.id_rx_addr = 0; bus.id_ry_addr = 0; bus.id_uses_rx = 0; bus.id_uses_ry = 0;
    t_exp = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    last_exp = pack(1'b1, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0, 16'h0800);
    exp_q.push_back(last_exp);
    check_out(0);
    bus.id_uses_rx = 1'b1;
    check_stall(1'b0, 0);
    bus.id_uses_rx = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) step(tbl[i], 1'b0, 1'b0, 100 + i);

    step(cmp55, 1'b0, 1'b0, 200);
    step(cmp56, 1'b0, 1'b0, 201);
    step(cmp55, 1'b1, 1'b0, 202);
    step(cmp55, 1'b0, 1'b1, 203);

    step(sw, 1'b0, 1'b1, 300);
    step(sw, 1'b0, 1'b0, 301);
    step(addiu, 1'b1, 1'b0, 302);
    step(addiu, 1'b1, 1'b1, 303);

    step(lw3, 1'b0, 1'b0, 400);
    bus.id_rx_addr = 4'd3; bus.id_uses_rx = 1'b1;
    check_stall(1'b1, 401);
    bus.id_uses_rx = 1'b0;
    check_stall(1'b0, 402);
    bus.id_ry_addr = 4'd3; bus.id_uses_ry = 1'b1;
    check_stall(1'b1, 403);
    bus.id_ry_addr = 4'd4;
    check_stall(1'b0, 404);
    bus.id_ry_addr = 4'd3;
    step(nop, 1'b0, 1'b1, 405);
    check_stall(1'b0, 406);
    bus.id_uses_ry = 1'b0;

    step(cmp56, 1'b0, 1'b0, 500);
    step(lw3, 1'b0, 1'b0, 501);
    bus.id_rx_addr = 4'd3; bus.id_uses_rx = 1'b1;
    check_stall(1'b1, 502);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    t_exp = 1'b0;
    last_exp = pack(1'b1, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0, 16'h0800);
    exp_q.push_back(last_exp);
    #1;
    check_out(503);
    check_stall(1'b0, 504);
    bus.id_uses_rx = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(addiu, 1'b0, 1'b0, 505);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
